muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/params_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared multiply/divide operation encoding and operand-sign helpers.
package params_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_t;

  // Returns {rs1 is signed, rs2 is signed}.
  function automatic logic [1:0] op_signed(input muldiv_op_t op);
    case (op)
      OpMul, OpMulh, OpDiv, OpRem: return 2'b11;
      OpMulhsu:                    return 2'b10;
      default:                     return 2'b00;
    endcase
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_step (
  input  logic        is_div_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] operand_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [31:0] rem_sub;
  logic        fits;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : 33'd0);
    shifted = {hi_i, lo_i[31]};
    fits    = shifted >= {1'b0, operand_i};
    // The true difference is below the divisor, so the low 32 bits are exact.
    rem_sub = shifted[31:0] - operand_i;
    if (is_div_i) begin
      hi_o = fits ? rem_sub : shifted[31:0];
      lo_o = {lo_i[30:0], fits};
    end else begin
      hi_o = sum[32:1];
      lo_o = {sum[0], lo_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit. Optional MULDIV_FAST_MUL_EN selects a
// single-cycle multiplier; otherwise every multiply runs the 32-step iterative path.
module muldiv_seq
  import params_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        kill_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCalc  = 2'd1;
  localparam logic [1:0] StFixup = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  muldiv_op_t  op_q, op_d;
  logic        neg_q, neg_d;
  logic        neg_a_q, neg_a_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] result_q, result_d;

  muldiv_op_t  op_in;
  logic [1:0]  sgn;
  logic        a_neg, b_neg, in_div, div_zero, div_ovf, accept;
  logic [31:0] mag_a, mag_b;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_fix;
  logic [31:0] fix_result;

  assign op_in    = muldiv_op_t'(op_i);
  assign sgn      = op_signed(op_in);
  assign a_neg    = sgn[1] & a_i[31];
  assign b_neg    = sgn[0] & b_i[31];
  assign mag_a    = a_neg ? -a_i : a_i;
  assign mag_b    = b_neg ? -b_i : b_i;
  assign in_div   = op_is_div(op_in);
  assign div_zero = in_div && (b_i == 32'd0);
  assign div_ovf  = (op_in inside {OpDiv, OpRem}) && (a_i == 32'h8000_0000) && (b_i == '1);
  assign accept   = (state_q == StIdle) && start_i && !kill_i;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_prod;
  assign fast_prod = $signed({a_neg, a_i}) * $signed({b_neg, b_i});
`endif

  muldiv_step u_step (
    .is_div_i  (op_is_div(op_q)),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .operand_i (opnd_q),
    .hi_o      (step_hi),
    .lo_o      (step_lo)
  );

  // Multiply leaves the product in {hi, lo}; divide leaves remainder in hi, quotient in lo.
  always_comb begin
    prod_fix   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    fix_result = prod_fix[63:32];
    unique case (op_q)
      OpMul:                     fix_result = prod_fix[31:0];
      OpMulh, OpMulhsu, OpMulhu: fix_result = prod_fix[63:32];
      OpDiv, OpDivu:             fix_result = neg_q ? -lo_q : lo_q;
      OpRem, OpRemu:             fix_result = neg_a_q ? -hi_q : hi_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    neg_a_d  = neg_a_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = op_in;
          neg_d   = a_neg ^ b_neg;
          neg_a_d = a_neg;
          hi_d    = 32'd0;
          lo_d    = in_div ? mag_a : mag_b;
          opnd_d  = in_div ? mag_b : mag_a;
          if (div_zero) begin
            result_d = (op_in inside {OpRem, OpRemu}) ? a_i : 32'hFFFF_FFFF;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = (op_in == OpRem) ? 32'd0 : 32'h8000_0000;
            state_d  = StDone;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!in_div) begin
            result_d = (op_in == OpMul) ? fast_prod[31:0] : fast_prod[63:32];
            state_d  = StDone;
`endif
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (kill_i) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StFixup;
        end
      end
      StFixup: begin
        if (kill_i) begin
          state_d = StIdle;
        end else begin
          result_d = fix_result;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      opnd_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      neg_a_q  <= neg_a_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = accept || (state_q == StCalc) || (state_q == StFixup);
  assign done_o   = (state_q == StDone) && !kill_i;
  assign result_o = result_q;

endmodule
